// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the RV32I load/store unit.
//   lsu_state_e  - FSM state encoding (IDLE, REQ, WAIT_R, DONE)
//   F3_*         - funct3 width encodings understood by the unit
//   FAULT_*      - fault codes reported alongside done
//   lsu_check()  - classifies a request as legal, misaligned or illegal
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    DONE   = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_ILLEGAL  = 2'b10;

  // Illegal takes priority over misaligned. Once a request is known to be
  // legal, funct3[1:0] alone identifies byte/half/word for loads and stores.
  function automatic logic [1:0] lsu_check(input logic       is_load,
                                           input logic       is_store,
                                           input logic [2:0] f3,
                                           input logic [1:0] off);
    logic illegal;
    logic misalign;
    illegal  = (is_load == is_store) ||
               (is_load  && (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111)) ||
               (is_store && (f3 >= 3'b011));
    misalign = ((f3[1:0] == 2'b01) && off[0]) ||
               ((f3[1:0] == 2'b10) && (off != 2'b00));
    if (illegal)       return FAULT_ILLEGAL;
    else if (misalign) return FAULT_MISALIGN;
    else               return FAULT_NONE;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: purely combinational lane steering for the load/store unit.
//   i_funct3      - access width / signedness
//   i_offset      - byte offset within the word (addr[1:0])
//   i_store_data  - rs2 value
//   i_rdata       - raw read word from memory
//   o_be          - byte enables for the access
//   o_wdata       - store data replicated across all lanes
//   o_load_data   - read word shifted down and sign/zero extended
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data
);

  logic [31:0] w_shifted;

  // Bring the addressed byte/halfword down to bit 0.
  assign w_shifted = i_rdata >> {i_offset, 3'b000};

  // Replicating the data lets the memory pick whichever lane be selects.
  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_store_data;
    case (i_funct3[1:0])
      2'b00: begin
        o_be    = 4'b0001 << i_offset;
        o_wdata = {4{i_store_data[7:0]}};
      end
      2'b01: begin
        o_be    = i_offset[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_store_data[15:0]}};
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_store_data;
      end
    endcase
  end

  always_comb begin
    o_load_data = w_shifted;
    case (i_funct3)
      F3_B:    o_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_BU:   o_load_data = {24'd0, w_shifted[7:0]};
      F3_H:    o_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_HU:   o_load_data = {16'd0, w_shifted[15:0]};
      default: o_load_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: RV32I load/store unit, one memory transaction per request.
//   clk, rst_n          - clock and asynchronous active-low reset
//   i_start ..          - request (is_load, is_store, funct3, addr, store_data)
//   o_busy, o_done      - in-flight flag and one-cycle completion pulse
//   o_load_data         - formatted load result, non-zero only with done
//   o_fault/_code       - request rejected without touching memory
//   o_mem_* / i_mem_*   - req/gnt/rvalid data-memory port
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN = 32  // only 32 is supported
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic            i_is_load,
  input  logic            i_is_store,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_store_data,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_load_data,
  output logic            o_fault,
  output logic [1:0]      o_fault_code,
  output logic            o_mem_req,
  output logic            o_mem_we,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [3:0]      o_mem_be,
  output logic [XLEN-1:0] o_mem_wdata,
  input  logic            i_mem_gnt,
  input  logic            i_mem_rvalid,
  input  logic [XLEN-1:0] i_mem_rdata
);

  lsu_state_e      r_state;
  logic            r_is_load;
  logic            r_is_store;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_store_data;
  logic [1:0]      r_fault_code;
  logic [XLEN-1:0] r_load_data;

  logic [1:0]      w_check;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_load_fmt;
  logic            w_in_req;
  logic            w_in_done;

  assign w_check = lsu_check(i_is_load, i_is_store, i_funct3, i_addr[1:0]);

  lsu_align u_align (
    .i_funct3     (r_funct3),
    .i_offset     (r_addr[1:0]),
    .i_store_data (r_store_data),
    .i_rdata      (i_mem_rdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_load_data  (w_load_fmt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_is_load    <= 1'b0;
      r_is_store   <= 1'b0;
      r_funct3     <= '0;
      r_addr       <= '0;
      r_store_data <= '0;
      r_fault_code <= FAULT_NONE;
      r_load_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_is_load    <= i_is_load;
            r_is_store   <= i_is_store;
            r_funct3     <= i_funct3;
            r_addr       <= i_addr;
            r_store_data <= i_store_data;
            r_fault_code <= w_check;
            r_load_data  <= '0;
            // Rejected requests skip memory entirely and report at once.
            r_state      <= (w_check != FAULT_NONE) ? DONE : REQ;
          end
        end
        REQ: begin
          if (i_mem_gnt) r_state <= r_is_load ? WAIT_R : DONE;
        end
        WAIT_R: begin
          if (i_mem_rvalid) begin
            r_load_data <= w_load_fmt;
            r_state     <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_in_req  = (r_state == REQ);
  assign w_in_done = (r_state == DONE);

  assign o_busy       = (r_state != IDLE);
  assign o_done       = w_in_done;
  assign o_fault      = w_in_done && (r_fault_code != FAULT_NONE);
  assign o_fault_code = w_in_done ? r_fault_code : FAULT_NONE;
  assign o_load_data  = (w_in_done && r_is_load && (r_fault_code == FAULT_NONE))
                        ? r_load_data : '0;

  // Memory side is driven straight from the latched request, so it stays
  // stable for the whole REQ phase and is forced to zero outside it.
  assign o_mem_req   = w_in_req;
  assign o_mem_we    = w_in_req && r_is_store;
  assign o_mem_addr  = w_in_req ? {r_addr[XLEN-1:2], 2'b00} : '0;
  assign o_mem_be    = w_in_req ? w_be : 4'b0000;
  assign o_mem_wdata = (w_in_req && r_is_store) ? w_wdata : '0;

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit in the RV32I execute→memory path.
- Consumes the ALU result as the effective address plus rs2 as store data.
- Runs one data-memory transaction over a req/gnt/rvalid handshake.
- Returns a sign- or zero-extended load result with a one-cycle done pulse.
- Detects misaligned accesses and illegal width encodings without touching memory.

Parameters:
- XLEN, 32, data/address width (only 32 supported).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request valid; accepted only when busy=0.
- is_load  in  1  request is a load.
- is_store  in  1  request is a store.
- funct3  in  3  RV32I width field: LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101.
- addr  in  32  effective address (ALU output).
- store_data  in  32  rs2 value.
- busy  out  1  high from the cycle after acceptance until the done cycle inclusive.
- done  out  1  one-cycle completion pulse.
- load_data  out  32  formatted load result; valid while done=1 for a load; 0 otherwise.
- fault  out  1  with done: request rejected, no memory access made.
- fault_code  out  2  01 misaligned, 10 illegal; 00 when fault=0.
- mem_req  out  1  memory request.
- mem_we  out  1  1=write.
- mem_addr  out  32  word address, {addr[31:2],2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read data word.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0. Reset mid-transaction drops mem_req immediately; any later rvalid is ignored.
- Acceptance: in IDLE with start=1, latch is_load, is_store, funct3, addr and store_data. Inputs are don't-care after that.
- Illegal request, checked at acceptance, evaluated first:
  - is_load==is_store;
  - load funct3 in {011,110,111};
  - store funct3 >=011.
  - Result: go to DONE with fault=1, fault_code=10.
- Misaligned request, checked at acceptance if not illegal:
  - halfword with addr[0]=1;
  - word with addr[1:0]!=00.
  - Result: go to DONE with fault=1, fault_code=01.
- Otherwise go to REQ.
- States: IDLE, REQ, WAIT_R, DONE.
- REQ:
  - mem_req=1 and mem_addr/mem_we/mem_be/mem_wdata stay stable until the cycle mem_gnt=1.
  - On gnt: a store goes to DONE; a load goes to WAIT_R.
  - No timeout.
- WAIT_R:
  - mem_req=0.
  - On mem_rvalid=1, register the formatted data and go to DONE.
  - Memory never asserts rvalid in the same cycle as gnt; the bench enforces this.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - start during DONE is ignored; the earliest next acceptance is the following IDLE cycle.
  - Back-to-back throughput:
    - store, gnt immediate: 1 request per 3 cycles;
    - load, rvalid next cycle: 4 cycles.
- start while busy: ignored, nothing latched.
- Store alignment, with o=addr[1:0]:
  - SB: be=4'b0001<<o; wdata={4{sd[7:0]}}.
  - SH: be=o[1]?1100:0011; wdata={2{sd[15:0]}}.
  - SW: be=1111; wdata=sd.
- Load formatting:
  - Shift: sh=mem_rdata>>(8*o).
  - LB: sign-extend sh[7:0]. LBU: zero-extend sh[7:0].
  - LH: sign-extend sh[15:0]. LHU: zero-extend sh[15:0].
  - LW: sh.
- Memory outputs are 0 whenever mem_req=0, except that mem_addr may hold its last value.

Decomposition:
- lsu_pkg holds:
  - enum lsu_state_e {IDLE,REQ,WAIT_R,DONE};
  - funct3 localparams F3_B/H/W/BU/HU;
  - fault codes FAULT_NONE/MISALIGN/ILLEGAL.
- One combinational sub-module, lsu_align, contains store lane/be generation and load shift/extend. It is purely combinational and testable standalone.
- The lsu top holds the FSM, request latches and the output registers.

Test Plan:
- SW addr=0x100, sd=0xDEADBEEF, gnt in the 2nd REQ cycle → mem_addr=0x100, be=1111, wdata=0xDEADBEEF held 2 cycles; done 1 cycle after gnt; fault=0.
- SB addr=0x203, sd=0x000000A5, gnt immediate → mem_addr=0x200, be=1000, wdata=0xA5A5A5A5.
- LB addr=0x11, rdata=0x0000_80_00 → load_data=0xFFFFFF80. Same with LBU → 0x00000080.
- LH addr=0x22, rdata=0x8001_1234 → 0xFFFF8001. LHU → 0x00008001. LW addr=0x24, rdata=0x12345678 → 0x12345678.
- LW addr=0x102 → done next cycle, fault=1, code=01, mem_req never asserted. is_load=is_store=1 → code=10. Store funct3=011 → code=10.
- rst_n low during WAIT_R, then rvalid pulses → no done, outputs 0. start during busy → ignored; the next request is accepted only after done.
